io_uart_bridge: RTL and testbench

//  Host-side endpoint for the CPU's word I/O ports: the other end of in_port/input_valid/input_ready
//  and out_port/output_valid. Receives UART bytes, packs pairs into 16-bit words and offers them to
//  the CPU with a valid/ready handshake. Captures CPU output words into a small FIFO and serializes

---
 rtl/io_pkg.sv | 29 ++
 rtl/io_txq.sv | 48 ++++
 rtl/io_uart_bridge.sv | 279 +++++++++++++++++++++++++++
 tb/tb_io_uart_bridge.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for the UART word bridge.
// Build option: define UART_PARITY_EN for 8E1 framing (even parity on TX, checked on RX).
package io_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  localparam logic UART_IDLE = 1'b1;
  localparam logic BYTE_LOW  = 1'b0;
  localparam logic BYTE_HIGH = 1'b1;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/io_txq.sv
// Small synchronous FIFO holding CPU output words until the UART transmitter takes them.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module io_txq #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A push while full is still accepted when a pop frees the slot on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Read and write pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/io_uart_bridge.sv
// Host-side UART endpoint for the CPU word I/O ports: RX bytes are paired into
// little-endian 16-bit words for in_port; out_port words are queued and sent as two bytes.
// Build option: define UART_PARITY_EN for even parity; otherwise 8N1.
module io_uart_bridge
  import io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int TXQ_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [15:0] cpu_in_port,
  output logic        cpu_input_valid,
  input  logic        cpu_input_ready,
  input  logic [15:0] cpu_out_port,
  input  logic        cpu_output_valid,
  input  logic        clr_status,
  output logic        rx_overrun,
  output logic        rx_frame_err,
  output logic        tx_overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic      rx_meta;
  logic      rx_sync;
  rx_state_t rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_byte;
  logic [7:0]    rx_low;
  logic          rx_phase;
`ifdef UART_PARITY_EN
  logic          rx_par_ok;
`endif
  logic          rx_xfer;

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_byte;
  logic [7:0]    tx_hi;
  logic          tx_half;

  logic          q_push;
  logic          q_pop;
  logic          q_full;
  logic          q_empty;
  logic [15:0]   q_dout;
  logic          tx_bypass;
  logic [15:0]   tx_word;

  assign rx_xfer = cpu_input_valid && cpu_input_ready;

  // Two-flop synchronizer for the asynchronous serial input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= UART_IDLE;
      rx_sync <= UART_IDLE;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // Receiver FSM, byte pairing, CPU-side handshake and RX sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state        <= RX_IDLE;
      rx_cnt          <= '0;
      rx_bit          <= '0;
      rx_byte         <= '0;
      rx_low          <= '0;
      rx_phase        <= BYTE_LOW;
`ifdef UART_PARITY_EN
      rx_par_ok       <= 1'b0;
`endif
      cpu_in_port     <= '0;
      cpu_input_valid <= 1'b0;
      rx_overrun      <= 1'b0;
      rx_frame_err    <= 1'b0;
    end else begin
      if (clr_status) begin
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
      end
      if (rx_xfer) cpu_input_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_sync == 1'b0) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt  <= '0;
            rx_byte <= {rx_sync, rx_byte[7:1]};
            if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt    <= '0;
            rx_par_ok <= (rx_sync == even_parity(rx_byte));
            rx_state  <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
`endif
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
`ifdef UART_PARITY_EN
            if (rx_sync && rx_par_ok) begin
`else
            if (rx_sync) begin
`endif
              if (rx_phase == BYTE_LOW) begin
                rx_low   <= rx_byte;
                rx_phase <= BYTE_HIGH;
              end else begin
                rx_phase <= BYTE_LOW;
                if (!cpu_input_valid || rx_xfer) begin
                  cpu_in_port     <= {rx_byte, rx_low};
                  cpu_input_valid <= 1'b1;
                end else begin
                  rx_overrun <= 1'b1;
                end
              end
            end else begin
              rx_frame_err <= 1'b1;
              rx_phase     <= BYTE_LOW;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // An idle transmitter with an empty queue takes a fresh strobe directly,
  // so the start bit appears the cycle after the strobe.
  assign tx_bypass = (tx_state == TX_IDLE) && q_empty && cpu_output_valid;
  assign q_pop     = (tx_state == TX_IDLE) && !q_empty;
  assign q_push    = cpu_output_valid && !tx_bypass;
  assign tx_word   = q_pop ? q_dout : cpu_out_port;

  io_txq #(
    .DEPTH(TXQ_DEPTH),
    .WIDTH(16)
  ) u_txq (
    .clk  (clk),
    .rst_n(rst_n),
    .push (q_push),
    .pop  (q_pop),
    .din  (cpu_out_port),
    .dout (q_dout),
    .full (q_full),
    .empty(q_empty)
  );

  // Transmitter FSM: low byte then high byte, plus the TX overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_byte     <= '0;
      tx_hi       <= '0;
      tx_half     <= 1'b0;
      uart_tx     <= UART_IDLE;
      tx_overflow <= 1'b0;
    end else begin
      if (clr_status) tx_overflow <= 1'b0;
      if (q_push && q_full && !q_pop) tx_overflow <= 1'b1;
      case (tx_state)
        TX_IDLE: begin
          tx_cnt  <= '0;
          uart_tx <= UART_IDLE;
          if (q_pop || tx_bypass) begin
            tx_byte  <= tx_word[7:0];
            tx_hi    <= tx_word[15:8];
            tx_half  <= 1'b0;
            uart_tx  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            uart_tx  <= tx_byte[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              uart_tx  <= even_parity(tx_byte);
              tx_state <= TX_PARITY;
`else
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
`endif
            end else begin
              tx_bit  <= tx_bit + 3'd1;
              uart_tx <= tx_byte[tx_bit + 3'd1];
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            uart_tx  <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
`endif
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (!tx_half) begin
              tx_half  <= 1'b1;
              tx_byte  <= tx_hi;
              uart_tx  <= 1'b0;
              tx_state <= TX_START;
            end else begin
              uart_tx  <= UART_IDLE;
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: begin
          uart_tx  <= UART_IDLE;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_bridge.sv
// Testbench for io_uart_bridge with CLKS_PER_BIT=16, TXQ_DEPTH=4.
// Honours UART_PARITY_EN when defined.
module tb_io_uart_bridge;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME_BITS = 10 + PB;
  localparam int BYTE_CYC   = FRAME_BITS * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic [15:0] cpu_in_port;
  logic        cpu_input_valid;
  logic        cpu_input_ready = 1'b0;
  logic [15:0] cpu_out_port = '0;
  logic        cpu_output_valid = 1'b0;
  logic        clr_status = 1'b0;
  logic        rx_overrun;
  logic        rx_frame_err;
  logic        tx_overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Serial line decoder results
  logic [7:0] mon_bytes[$];
  int         mon_start[$];
  logic       mon_par[$];
  int         mon_bad = 0;

  io_uart_bridge #(
    .CLKS_PER_BIT(CPB),
    .TXQ_DEPTH(DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .uart_rx         (uart_rx),
    .uart_tx         (uart_tx),
    .cpu_in_port     (cpu_in_port),
    .cpu_input_valid (cpu_input_valid),
    .cpu_input_ready (cpu_input_ready),
    .cpu_out_port    (cpu_out_port),
    .cpu_output_valid(cpu_output_valid),
    .clr_status      (clr_status),
    .rx_overrun      (rx_overrun),
    .rx_frame_err    (rx_frame_err),
    .tx_overflow     (tx_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Independent UART receiver watching uart_tx, sampling mid-bit on falling clock edges.
  initial begin
    logic [7:0] b;
    logic       start_ok;
    logic       stop_ok;
    int         t0;
    forever begin
      @(negedge uart_tx);
      @(negedge clk);
      t0 = cyc;
      repeat (CPB / 2 - 1) @(negedge clk);
      start_ok = (uart_tx === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = uart_tx;
      end
      if (PB == 1) begin
        repeat (CPB) @(negedge clk);
        mon_par.push_back(uart_tx);
      end
      repeat (CPB) @(negedge clk);
      stop_ok = (uart_tx === 1'b1);
      if (!start_ok || !stop_ok) mon_bad++;
      mon_bytes.push_back(b);
      mon_start.push_back(t0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle CPU output strobe
  task automatic applyStimulus(input logic [15:0] w);
    cpu_out_port     = w;
    cpu_output_valid = 1'b1;
    tick();
    cpu_output_valid = 1'b0;
  endtask

  function automatic logic [10:0] frameOf(input logic [7:0] b, input logic stop_bit);
`ifdef UART_PARITY_EN
    return {stop_bit, ^b, b, 1'b0};
`else
    return {1'b0, stop_bit, b, 1'b0};
`endif
  endfunction

  // Drive one serial frame (bit 0 first) followed by one idle bit time
  task automatic sendRxFrame(input logic [10:0] bits);
    for (int i = 0; i < FRAME_BITS; i++) begin
      uart_rx = bits[i];
      repeat (CPB) tick();
    end
    uart_rx = 1'b1;
    repeat (CPB) tick();
  endtask

  task automatic sendRxWord(input logic [15:0] w);
    sendRxFrame(frameOf(w[7:0], 1'b1));
    sendRxFrame(frameOf(w[15:8], 1'b1));
  endtask

  task automatic pulseReady();
    cpu_input_ready = 1'b1;
    tick();
    cpu_input_ready = 1'b0;
  endtask

  task automatic pulseClr();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  task automatic waitBytes(input int n, input int budget);
    int k;
    k = 0;
    while (mon_bytes.size() < n && k < budget) begin
      tick();
      k++;
    end
    checkOutput("tx_byte_count", mon_bytes.size(), n);
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] ws[4];
    logic [15:0] exp_words[$];
    logic [7:0]  b;
    int          qcount;
    logic        exp_ovf;

    // Reset values while held in reset
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_uart_tx", uart_tx, 1);
    checkOutput("reset_in_port", cpu_in_port, 0);
    checkOutput("reset_valid", cpu_input_valid, 0);
    checkOutput("reset_overrun", rx_overrun, 0);
    checkOutput("reset_frame_err", rx_frame_err, 0);
    checkOutput("reset_overflow", tx_overflow, 0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Basic word receive and handshake
    sendRxWord(16'h1234);
    checkOutput("rx_word_1234", cpu_in_port, 16'h1234);
    checkOutput("rx_valid_set", cpu_input_valid, 1);
    repeat (20) tick();
    checkOutput("rx_valid_held", cpu_input_valid, 1);
    checkOutput("rx_word_held", cpu_in_port, 16'h1234);
    pulseReady();
    checkOutput("rx_valid_drop", cpu_input_valid, 0);

    // Randomized words with handshake
    for (int i = 0; i < 3; i++) begin
      w = 16'($urandom);
      sendRxWord(w);
      checkOutput("rx_rand_word", cpu_in_port, w);
      checkOutput("rx_rand_valid", cpu_input_valid, 1);
      pulseReady();
      checkOutput("rx_rand_drop", cpu_input_valid, 0);
    end
    checkOutput("rx_no_overrun", rx_overrun, 0);

    // Overrun: the first of four unconsumed words is retained
    for (int i = 0; i < 4; i++) begin
      ws[i] = 16'($urandom);
      sendRxWord(ws[i]);
    end
    checkOutput("ovr_first_kept", cpu_in_port, ws[0]);
    checkOutput("ovr_flag", rx_overrun, 1);
    pulseClr();
    checkOutput("ovr_cleared", rx_overrun, 0);
    checkOutput("ovr_valid_kept", cpu_input_valid, 1);
    pulseReady();
    checkOutput("ovr_valid_drop", cpu_input_valid, 0);

    // Framing error mid-word resets the byte phase
    b = 8'($urandom);
    sendRxFrame(frameOf(b, 1'b1));
    sendRxFrame(frameOf(8'($urandom), 1'b0));
    checkOutput("fe_flag", rx_frame_err, 1);
    checkOutput("fe_no_word", cpu_input_valid, 0);
    sendRxWord(16'hABCD);
    checkOutput("fe_word", cpu_in_port, 16'hABCD);
    checkOutput("fe_valid", cpu_input_valid, 1);
    pulseReady();
    pulseClr();
    checkOutput("fe_cleared", rx_frame_err, 0);

    // TX single word from idle
    mon_bytes.delete();
    mon_start.delete();
    mon_par.delete();
    cpu_out_port     = 16'hBEEF;
    cpu_output_valid = 1'b1;
    checkOutput("tx_idle_high", uart_tx, 1);
    tick();
    cpu_output_valid = 1'b0;
    checkOutput("tx_start_next", uart_tx, 0);
    waitBytes(2, 3 * BYTE_CYC);
    checkOutput("tx_byte_lo", mon_bytes[0], 8'hEF);
    checkOutput("tx_byte_hi", mon_bytes[1], 8'hBE);
    checkOutput("tx_byte_spacing", mon_start[1] - mon_start[0], BYTE_CYC);
    repeat (CPB) tick();

    // TX queue overflow while transmitter busy
    mon_bytes.delete();
    mon_start.delete();
    mon_par.delete();
    exp_words.delete();
    qcount  = 0;
    exp_ovf = 1'b0;
    w = 16'($urandom);
    applyStimulus(w);
    exp_words.push_back(w);
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      w = 16'($urandom);
      applyStimulus(w);
      if (qcount < DEPTH) begin
        exp_words.push_back(w);
        qcount++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    checkOutput("tx_overflow_flag", tx_overflow, exp_ovf);
    waitBytes(2 * exp_words.size(), (2 * exp_words.size() + 2) * BYTE_CYC);
    repeat (2 * BYTE_CYC) tick();
    checkOutput("tx_exact_count", mon_bytes.size(), 2 * exp_words.size());
    for (int i = 0; i < exp_words.size(); i++) begin
      checkOutput("tx_q_lo", mon_bytes[2 * i], exp_words[i][7:0]);
      checkOutput("tx_q_hi", mon_bytes[2 * i + 1], exp_words[i][15:8]);
    end
    pulseClr();
    checkOutput("tx_overflow_clr", tx_overflow, 0);

`ifdef UART_PARITY_EN
    // Parity error on RX and parity bits on TX
    sendRxFrame({1'b1, 1'b0, 8'h07, 1'b0});
    checkOutput("par_rx_err", rx_frame_err, 1);
    checkOutput("par_rx_no_word", cpu_input_valid, 0);
    pulseClr();
    mon_bytes.delete();
    mon_start.delete();
    mon_par.delete();
    applyStimulus(16'h0101);
    waitBytes(2, 3 * BYTE_CYC);
    checkOutput("par_tx_b0", mon_bytes[0], 8'h01);
    checkOutput("par_tx_b1", mon_bytes[1], 8'h01);
    checkOutput("par_tx_p0", mon_par[0], 1);
    checkOutput("par_tx_p1", mon_par[1], 1);
    repeat (CPB) tick();
`endif

    checkOutput("tx_frames_clean", mon_bad, 0);

    // Reset mid-frame aborts transmission immediately
    applyStimulus(16'($urandom));
    repeat (3 * CPB + 5) tick();
    checkOutput("mid_frame_busy", uart_tx === 1'b1 || uart_tx === 1'b0, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_uart_tx", uart_tx, 1);
    checkOutput("abort_valid", cpu_input_valid, 0);
    checkOutput("abort_overflow", tx_overflow, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2 * BYTE_CYC) tick();
    checkOutput("abort_stays_idle", uart_tx, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
